// File: rtl/fst_run_monitor.sv
// Run controller/monitor for the fst core: sequences core reset, counts RUN cycles,
// stops on halt, stuck PC or cycle overflow. Define FST_MON_BREAK_EN to add a PC breakpoint.
module fst_run_monitor #(
   parameter int unsigned PC_W        = 16,
   parameter int unsigned CYC_W       = 32,
   parameter int unsigned RST_HOLD    = 3,
   parameter int unsigned STALL_LIMIT = 1024
) (
   input  logic             clk_in,
   input  logic             reset_n_in,
   input  logic             start,
   input  logic [PC_W-1:0]  pc_in,
   input  logic             halting_in,
`ifdef FST_MON_BREAK_EN
   input  logic             bp_en,
   input  logic [PC_W-1:0]  bp_addr,
`endif
   output logic             cpu_reset_n,
   output logic             running,
   output logic             done,
   output logic             fault,
   output logic [1:0]       err_code,
   output logic [CYC_W-1:0] cycle_count,
   output logic [PC_W-1:0]  stop_pc
);

   localparam int unsigned ST_W   = $clog2(STALL_LIMIT) + 1;
   localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

   typedef enum logic [2:0] {S_IDLE, S_RST, S_RUN, S_HALTED, S_FAULT} state_t;

   state_t            state;
   logic [HOLD_W-1:0] hold_cnt;
   logic [ST_W-1:0]   stall_cnt;
   logic [PC_W-1:0]   prev_pc;
   logic              first_run;

   logic [CYC_W-1:0]  cyc_next;
   logic              pc_same;
   logic              stall_hit;
   logic              ovf_hit;
   logic              bp_hit;
   logic              run_exit;

   always_comb begin
      cyc_next  = (cycle_count == '1) ? cycle_count : cycle_count + CYC_W'(1);
      pc_same   = (pc_in == prev_pc);
      // stall_cnt counts equal compares, so STALL_LIMIT identical PCs give STALL_LIMIT-1
      stall_hit = !first_run && pc_same && (stall_cnt == ST_W'(STALL_LIMIT - 2));
      ovf_hit   = (cyc_next == '1);
      bp_hit    = 1'b0;
`ifdef FST_MON_BREAK_EN
      bp_hit    = !first_run && bp_en && (pc_in == bp_addr);
`endif
      run_exit  = halting_in || bp_hit || stall_hit || ovf_hit;
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state       <= S_IDLE;
         cpu_reset_n <= 1'b0;
         running     <= 1'b0;
         done        <= 1'b0;
         fault       <= 1'b0;
         err_code    <= 2'd0;
         cycle_count <= '0;
         stop_pc     <= '0;
         stall_cnt   <= '0;
         hold_cnt    <= '0;
         prev_pc     <= '0;
         first_run   <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_HALTED, S_FAULT: begin
               if (start) begin
                  state       <= S_RST;
                  cpu_reset_n <= 1'b0;
                  running     <= 1'b0;
                  done        <= 1'b0;
                  fault       <= 1'b0;
                  err_code    <= 2'd0;
                  cycle_count <= '0;
                  stop_pc     <= '0;
                  hold_cnt    <= '0;
               end
            end
            S_RST: begin
               if (hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
                  state       <= S_RUN;
                  cpu_reset_n <= 1'b1;
                  running     <= 1'b1;
                  first_run   <= 1'b1;
                  stall_cnt   <= '0;
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            S_RUN: begin
               cycle_count <= cyc_next;
               prev_pc     <= pc_in;
               first_run   <= 1'b0;
               stall_cnt   <= (first_run || !pc_same) ? '0 : stall_cnt + ST_W'(1);
               if (halting_in) begin
                  state    <= S_HALTED;
                  done     <= 1'b1;
                  err_code <= 2'd0;
               end else if (bp_hit) begin
                  state    <= S_HALTED;
                  done     <= 1'b1;
                  err_code <= 2'd3;
               end else if (stall_hit) begin
                  state    <= S_FAULT;
                  fault    <= 1'b1;
                  err_code <= 2'd1;
               end else if (ovf_hit) begin
                  state    <= S_FAULT;
                  fault    <= 1'b1;
                  err_code <= 2'd2;
               end
               if (run_exit) begin
                  running <= 1'b0;
                  stop_pc <= pc_in;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fst_run_monitor.sv
// Bench for fst_run_monitor: two instances (32-bit and 4-bit cycle counter) share stimulus and
// are checked every cycle against a run-level model; FST_MON_BREAK_EN enables breakpoint tests.
module tb_fst_run_monitor;

   localparam int unsigned RST_HOLD    = 3;
   localparam int unsigned STALL_LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        halting_in = 1'b0;
   logic [15:0] pc_in = '0;
`ifdef FST_MON_BREAK_EN
   logic        bp_en = 1'b0;
   logic [15:0] bp_addr = '0;
`endif

   logic        a_rn, a_run, a_done, a_fault;
   logic [1:0]  a_err;
   logic [31:0] a_cnt;
   logic [15:0] a_stop;
   logic        b_rn, b_run, b_done, b_fault;
   logic [1:0]  b_err;
   logic [3:0]  b_cnt;
   logic [15:0] b_stop;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fst_run_monitor #(.PC_W(16), .CYC_W(32), .RST_HOLD(RST_HOLD), .STALL_LIMIT(STALL_LIMIT)) dut_a (
      .clk_in(clk), .reset_n_in(reset_n), .start(start), .pc_in(pc_in), .halting_in(halting_in),
`ifdef FST_MON_BREAK_EN
      .bp_en(bp_en), .bp_addr(bp_addr),
`endif
      .cpu_reset_n(a_rn), .running(a_run), .done(a_done), .fault(a_fault),
      .err_code(a_err), .cycle_count(a_cnt), .stop_pc(a_stop));

   fst_run_monitor #(.PC_W(16), .CYC_W(4), .RST_HOLD(RST_HOLD), .STALL_LIMIT(STALL_LIMIT)) dut_b (
      .clk_in(clk), .reset_n_in(reset_n), .start(start), .pc_in(pc_in), .halting_in(halting_in),
`ifdef FST_MON_BREAK_EN
      .bp_en(bp_en), .bp_addr(bp_addr),
`endif
      .cpu_reset_n(b_rn), .running(b_run), .done(b_done), .fault(b_fault),
      .err_code(b_err), .cycle_count(b_cnt), .stop_pc(b_stop));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- run-level model: index 0 = dut_a, 1 = dut_b ----------------
   typedef enum {P_IDLE, P_RESETTING, P_RUN, P_HALTED, P_FAULT} phase_t;
   phase_t      m_phase[2];
   int          m_rst_left[2];
   bit          m_first[2];
   logic [15:0] m_prev[2];
   int          m_run_len[2];
   logic [31:0] m_count[2];
   logic [15:0] m_stop[2];
   logic [1:0]  m_err[2];
   logic [31:0] cyc_max[2] = '{32'hFFFF_FFFF, 32'h0000_000F};

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_phase[i] = P_IDLE; m_rst_left[i] = 0; m_first[i] = 0; m_prev[i] = '0;
         m_run_len[i] = 0; m_count[i] = '0; m_stop[i] = '0; m_err[i] = '0;
      end
   endtask

   task automatic model_step(input int i);
      bit bp;
      case (m_phase[i])
         P_IDLE, P_HALTED, P_FAULT:
            if (start) begin
               m_phase[i] = P_RESETTING; m_rst_left[i] = RST_HOLD;
               m_count[i] = '0; m_stop[i] = '0; m_err[i] = '0;
            end
         P_RESETTING: begin
            m_rst_left[i]--;
            if (m_rst_left[i] == 0) begin m_phase[i] = P_RUN; m_first[i] = 1; end
         end
         P_RUN: begin
            if (m_count[i] != cyc_max[i]) m_count[i] = m_count[i] + 1;
            // length of the current streak of identical PCs within this run
            if (m_first[i] || pc_in != m_prev[i]) m_run_len[i] = 1;
            else m_run_len[i]++;
            m_prev[i] = pc_in;
            bp = 0;
`ifdef FST_MON_BREAK_EN
            bp = !m_first[i] && bp_en && (pc_in == bp_addr);
`endif
            m_first[i] = 0;
            if (halting_in)                      begin m_phase[i] = P_HALTED; m_err[i] = 2'd0; end
            else if (bp)                         begin m_phase[i] = P_HALTED; m_err[i] = 2'd3; end
            else if (m_run_len[i] >= STALL_LIMIT) begin m_phase[i] = P_FAULT; m_err[i] = 2'd1; end
            else if (m_count[i] == cyc_max[i])   begin m_phase[i] = P_FAULT; m_err[i] = 2'd2; end
            if (m_phase[i] != P_RUN) m_stop[i] = pc_in;
         end
         default: ;
      endcase
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) model_reset();
      else for (int i = 0; i < 2; i++) model_step(i);
   end

   task automatic compare_one(input int i, input string tag, input logic rn, input logic run,
                              input logic dn, input logic ft, input logic [1:0] err,
                              input logic [31:0] cnt, input logic [15:0] stp);
      check({tag, ".cpu_reset_n"}, rn, m_phase[i] inside {P_RUN, P_HALTED, P_FAULT});
      check({tag, ".running"}, run, m_phase[i] == P_RUN);
      check({tag, ".done"}, dn, m_phase[i] == P_HALTED);
      check({tag, ".fault"}, ft, m_phase[i] == P_FAULT);
      check({tag, ".err_code"}, err, m_err[i]);
      check({tag, ".cycle_count"}, cnt, m_count[i]);
      check({tag, ".stop_pc"}, stp, m_stop[i]);
   endtask

   always @(negedge clk) begin
      compare_one(0, "a", a_rn, a_run, a_done, a_fault, a_err, a_cnt, a_stop);
      compare_one(1, "b", b_rn, b_run, b_done, b_fault, b_err, {28'd0, b_cnt}, b_stop);
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic run_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("rst_hold0.cpu_reset_n", a_rn, 1'b0);
      check("restart.done_drop", a_done, 1'b0);
      check("restart.fault_drop", a_fault, 1'b0);
      tick();
      check("rst_hold1.cpu_reset_n", a_rn, 1'b0);
      tick();
      check("rst_hold2.cpu_reset_n", a_rn, 1'b0);
      tick();
      check("run_entry.cpu_reset_n", a_rn, 1'b1);
      check("run_entry.running", a_run, 1'b1);
   endtask

   task automatic run_cycle(input logic [15:0] pc, input logic halt);
      pc_in = pc;
      halting_in = halt;
      tick();
   endtask

   initial begin
      #120;
      check("reset.cpu_reset_n", a_rn, 1'b0);
      check("reset.running", a_run, 1'b0);
      check("reset.cycle_count", a_cnt, 32'd0);
      check("reset.stop_pc", a_stop, 16'd0);
      #10 reset_n = 1'b1;
      tick();

      // normal halt on RUN cycle 20; the 4-bit instance overflows on cycle 15
      run_start();
      for (int k = 1; k <= 20; k++) begin
         run_cycle(16'(k - 1), k == 20);
         if (k == 1) check("first_run.cycle_count", a_cnt, 32'd1);
         if (k == 14) check("ovf.before", b_fault, 1'b0);
         if (k == 15) begin
            check("ovf.fault", b_fault, 1'b1);
            check("ovf.err_code", b_err, 2'd2);
            check("ovf.cycle_count", b_cnt, 4'hF);
            check("ovf.stop_pc", b_stop, 16'h000E);
         end
      end
      halting_in = 1'b0;
      check("halt.done", a_done, 1'b1);
      check("halt.err_code", a_err, 2'd0);
      check("halt.cycle_count", a_cnt, 32'd20);
      check("halt.stop_pc", a_stop, 16'h0013);
      for (int k = 0; k < 10; k++) run_cycle(16'($urandom), 1'b0);
      check("halt_hold.done", a_done, 1'b1);
      check("halt_hold.cycle_count", a_cnt, 32'd20);
      check("halt_hold.stop_pc", a_stop, 16'h0013);
      check("ovf_hold.cycle_count", b_cnt, 4'hF);

      // stall: PC stuck at 0x0040 from RUN cycle 5, then same with a halt on the fault cycle
      for (int v = 0; v < 2; v++) begin
         run_start();
         for (int k = 1; k <= 8; k++) begin
            run_cycle((k < 5) ? 16'(16'h0030 + k) : 16'h0040, (v == 1) && (k == 8));
            if (k == 7) check("stall.before", a_fault, 1'b0);
         end
         halting_in = 1'b0;
         if (v == 0) begin
            check("stall.fault", a_fault, 1'b1);
            check("stall.err_code", a_err, 2'd1);
            check("stall.stop_pc", a_stop, 16'h0040);
            check("stall.cycle_count", a_cnt, 32'd8);
         end else begin
            check("stall_prio.done", a_done, 1'b1);
            check("stall_prio.fault", a_fault, 1'b0);
            check("stall_prio.err_code", a_err, 2'd0);
         end
      end

      // asynchronous reset in the middle of RUN cycle 7
      run_start();
      for (int k = 1; k <= 6; k++) run_cycle(16'(16'h0100 + k), 1'b0);
      pc_in = 16'h0107;
      reset_n = 1'b0;
      #1;
      check("areset.cpu_reset_n", a_rn, 1'b0);
      check("areset.running", a_run, 1'b0);
      check("areset.cycle_count", a_cnt, 32'd0);
      check("areset.stop_pc", a_stop, 16'd0);
      check("areset.b_cpu_reset_n", b_rn, 1'b0);
      #1 reset_n = 1'b1;
      tick();
      run_start();
      run_cycle(16'h0200, 1'b0);
      check("fresh_run.cycle_count", a_cnt, 32'd1);
      for (int k = 1; k <= 4; k++) run_cycle(16'(16'h0200 + k), k == 4);
      halting_in = 1'b0;

`ifdef FST_MON_BREAK_EN
      bp_en = 1'b1;
      bp_addr = 16'h0010;
      run_start();
      for (int k = 1; k <= 17; k++) run_cycle(16'(k - 1), 1'b0);
      check("bp.done", a_done, 1'b1);
      check("bp.err_code", a_err, 2'd3);
      check("bp.stop_pc", a_stop, 16'h0010);
      run_start();
      run_cycle(16'h0010, 1'b0);
      check("bp_restart.running", a_run, 1'b1);
      for (int k = 1; k <= 4; k++) run_cycle(16'(16'h0010 + k), k == 4);
      halting_in = 1'b0;
      bp_en = 1'b0;
`endif

      // randomized traffic: frequent PC repeats, stray starts, rare halts and async resets
      for (int n = 0; n < 3000; n++) begin
         start = ($urandom_range(0, 29) == 0);
         halting_in = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 2) != 0) pc_in = 16'($urandom_range(0, 15));
`ifdef FST_MON_BREAK_EN
         if ($urandom_range(0, 49) == 0) begin
            bp_en = 1'($urandom);
            bp_addr = 16'($urandom_range(0, 15));
         end
`endif
         if ($urandom_range(0, 399) == 0) begin
            reset_n = 1'b0;
            #1 reset_n = 1'b1;
         end
         tick();
      end
      start = 1'b0;
      halting_in = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fst_run_monitor.md
Name: fst_run_monitor

Overview:
- Synthesizable run controller and monitor for the fst core.
- Sequences the core's reset, then counts executed cycles while the core runs.
- Stops the run on a halt, a stuck PC or cycle-count overflow, and captures the PC and status at that point.
- Sits between the board/top-level and fst, replacing fixed-delay reset and assert-on-halt logic with parametrised hardware usable on FPGA and in simulation.

Parameters:
- PC_W, 16, width of the monitored program counter.
- CYC_W, 32, width of the cycle counter.
- RST_HOLD, 3, cycles cpu_reset_n is held low per run (must be ≥1).
- STALL_LIMIT, 1024, consecutive cycles of unchanged PC that constitute a stall fault (must be ≥2).

Ports:
- clk_in, input, 1, single clock.
- reset_n_in, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse that begins or restarts a run.
- pc_in, input, PC_W, core PC (fst pc_out).
- halting_in, input, 1, core halt flag.
- cpu_reset_n, output, 1, reset to core (active low).
- running, output, 1, high in RUN.
- done, output, 1, high in HALTED.
- fault, output, 1, high in FAULT.
- err_code, output, 2, 0 none, 1 stall, 2 cycle overflow, 3 breakpoint.
- cycle_count, output, CYC_W, RUN cycles elapsed this run.
- stop_pc, output, PC_W, pc_in sampled on the cycle the run ended.

Behaviour:
- Reset and clock: reset_n_in is asynchronous, active-low; the single clock is clk_in. All state is on rising clk_in.
- Reset values: state=IDLE, cpu_reset_n=0, running=0, done=0, fault=0, err_code=0, cycle_count=0, stop_pc=0, stall counter=0, hold counter=0.
- States: IDLE, RST, RUN, HALTED, FAULT. Outputs are registered Moore outputs of state.
- IDLE: cpu_reset_n=0. On start, go to RST; clear cycle_count, stop_pc and err_code.
- RST:
  - cpu_reset_n=0 for exactly RST_HOLD cycles.
  - Hold counter reaches RST_HOLD-1 → RUN. The first RUN cycle has cpu_reset_n=1.
- RUN: cpu_reset_n=1, running=1. Each cycle:
  - cycle_count += 1.
  - Compare pc_in with the registered previous pc_in. Equal → stall counter += 1; different → stall counter = 0. The first RUN cycle resets the previous-PC register and the stall counter.
- RUN exit priority, highest first:
  1. halting_in → HALTED, err_code=0.
  2. Breakpoint hit (optional feature) → HALTED, err_code=3.
  3. Stall counter reaches STALL_LIMIT-1 on an equal compare → FAULT, err_code=1.
  4. cycle_count == all-ones → FAULT, err_code=2; cycle_count holds all-ones (saturates, never wraps).
- On any RUN exit, stop_pc ← pc_in of that cycle and cycle_count includes that cycle.
- HALTED/FAULT:
  - cpu_reset_n stays 1 so the core state remains inspectable.
  - cycle_count and stop_pc are frozen.
  - start → RST: counters and err_code cleared, done/fault drop on the next cycle.
- start in RST or RUN is ignored.
- reset_n_in asserted in any state: immediately (asynchronously) returns all outputs to reset values, including mid-RST and mid-RUN. cpu_reset_n goes low combinationally via the flop's async clear.
- Width rule: cycle_count and the stall counter are unsigned. The stall counter is sized $clog2(STALL_LIMIT)+1.

Optional Feature:
- Macro: FST_MON_BREAK_EN.
- When defined:
  - Adds inputs bp_en (1) and bp_addr (PC_W).
  - In RUN, if bp_en and pc_in==bp_addr → HALTED, err_code=3, stop_pc=bp_addr.
  - Priority is below halting_in and above stall.
  - The breakpoint is not checked on the first RUN cycle, so a restart from a breakpoint PC does not re-trigger immediately.
- When undefined: ports absent, err_code 3 never produced.

Test Plan:
1. Reset/sequence: RST_HOLD=3, reset_n_in low 130 ns then high, start pulse → cpu_reset_n low exactly 3 cycles after start is sampled, then high with running=1; cycle_count=1 after the first RUN edge.
2. Normal halt: pc_in increments each cycle, halting_in rises on RUN cycle 20 with pc_in=0x0013 → done=1, err_code=0, cycle_count=20, stop_pc=0x0013, all held 10 further cycles.
3. Stall: STALL_LIMIT=4, pc_in held at 0x0040 from RUN cycle 5 → fault=1, err_code=1, stop_pc=0x0040. The same stimulus with halting_in asserted on the fault cycle → done=1, err_code=0 (priority).
4. Overflow: CYC_W=4, no halt, changing PC → fault on RUN cycle 15, err_code=2, cycle_count=4'hF, and it stays 4'hF.
5. Async reset mid-run: reset_n_in pulsed low between clock edges at RUN cycle 7 → all outputs are reset values before the next edge; start afterwards gives a fresh run with cycle_count starting at 1.
6. FST_MON_BREAK_EN: bp_en=1, bp_addr=0x0010, incrementing PC from 0 → done=1, err_code=3, stop_pc=0x0010. Restart with pc_in starting at 0x0010 → no hit on the first RUN cycle.
